// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_fetch_ctrl : single-outstanding instruction fetch over req/gnt/rvalid |
// |                   with misaligned, bus-error and timeout fault reporting   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module imem_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h00000000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  pc_load,
  input  logic                  flush,
  output logic                  fetch_busy,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetch_err,
  output logic [1:0]            err_code,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] tcount;
  logic             cnt_last;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             req_set;
  logic             req_clr;
  logic             capture;
  logic             err_set;
  logic [1:0]       err_code_nxt;

  assign fetch_busy = (state != ST_IDLE);
  assign cnt_last   = (tcount == CNT_LAST);

  // Flush has priority over any response in WAIT; rvalid beats timeout.
  always_comb begin
    state_nxt    = state;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    req_set      = 1'b0;
    req_clr      = 1'b0;
    capture      = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = ERR_MISALIGN;
    case (state)
      ST_IDLE: begin
        if (pc_load) begin
          if (pc_next[1:0] != 2'b00) begin
            err_set      = 1'b1;
            err_code_nxt = ERR_MISALIGN;
          end else begin
            req_set   = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          req_clr   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          req_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          if (mem_rvalid) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end else if (mem_rvalid) begin
          state_nxt = ST_IDLE;
          if (mem_err) begin
            err_set      = 1'b1;
            err_code_nxt = ERR_BUS;
          end else begin
            capture = 1'b1;
          end
        end else if (cnt_last) begin
          state_nxt    = ST_IDLE;
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_rvalid || cnt_last) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (req_set) begin
      mem_req  <= 1'b1;
      mem_addr <= pc_next;
    end else if (req_clr) begin
      mem_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount <= '0;
    end else if (cnt_clr) begin
      tcount <= '0;
    end else if (cnt_inc) begin
      tcount <= tcount + CNT_W'(1);
    end
  end

  // mem_addr is still the fetched address while the response is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
    end else begin
      instr_valid <= capture;
      if (capture) begin
        instr    <= mem_rdata;
        instr_pc <= mem_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      fetch_err <= err_set;
      if (err_set) begin
        err_code <= err_code_nxt;
      end
    end
  end

endmodule
`default_nettype wire
